detector_colision: RTL and testbench

DETECTOR_COLISION -- requirements
Module: detector_colision

---
 rtl/detector_colision_if.sv | 10 +
 rtl/detector_colision.sv | 151 +++++++++++++++
 tb/tb_detector_colision.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/detector_colision_if.sv
// Obstacle-generator link: tick, obstacle type and display in; bonus-taken strobe back.
interface detector_colision_if;
   logic        clk_obstaculos;
   logic [4:0]  tipo_obs;
   logic [20:0] display_obs;
   logic        bono_tomado;

   modport master (output clk_obstaculos, tipo_obs, display_obs, input bono_tomado);
   modport slave  (input clk_obstaculos, tipo_obs, display_obs, output bono_tomado);
endinterface

// File: rtl/detector_colision.sv
// Hero collision detector: jump timing, dodge scoring, bonus pickup and win/lose result.
// Optional macro VIDAS_EN: three lives instead of a single one.
//
// state | meaning
// IDLE  | not in play, scores/lives/pipeline cleared, hero hidden
// RUN   | waiting for an obstacle tick; jump presses accepted here
// EVAL  | one clk: judge the obstacle that just reached the hero digit
// WIN   | bonus taken in world 2, result held
// LOSE  | out of lives, result held
module detector_colision #(
   parameter logic [2:0] GAME      = 3'd3,
   parameter logic [4:0] BONO_TIPO = 5'd16,
   parameter int         T_SALTO   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   detector_colision_if.slave  obs_if,
   input  logic [2:0]          i_presente,
   input  logic [1:0]          i_mundo,
   input  logic                i_salto,
   output logic [1:0]          o_W_or_L,
   output logic [6:0]          o_heroe_seg,
   output logic [7:0]          o_puntos,
   output logic [1:0]          o_vidas
);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_EVAL, S_WIN, S_LOSE} state_t;

   localparam logic [1:0] SALTO_LD = 2'(T_SALTO);

   state_t      r_state, w_next;
   logic        r_obs_s1, r_obs_s2, r_obs_d;
   logic        r_salto_s1, r_salto_s2, r_salto_d;
   logic [4:0]  r_p2, r_p1, r_p0;
   logic [1:0]  r_salto_cnt;
   logic [7:0]  r_puntos;
   logic        r_bono;
   logic        r_tick_pend;
   logic        w_tick, w_salto_rise, w_tick_svc;
   logic        w_event, w_bono, w_hit, w_dodge, w_last_life;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {r_obs_s1, r_obs_s2, r_obs_d}       <= 3'b000;
         {r_salto_s1, r_salto_s2, r_salto_d} <= 3'b000;
      end else begin
         {r_obs_s1, r_obs_s2, r_obs_d}       <= {obs_if.clk_obstaculos, r_obs_s1, r_obs_s2};
         {r_salto_s1, r_salto_s2, r_salto_d} <= {i_salto, r_salto_s1, r_salto_s2};
      end
   end

   assign w_tick       = r_obs_s2 & ~r_obs_d;
   assign w_salto_rise = r_salto_s2 & ~r_salto_d;
   assign w_tick_svc   = w_tick | r_tick_pend;

   assign w_event = (obs_if.display_obs[6:0] != 7'd0) && (r_p0 != 5'd0);
   assign w_bono  = w_event && (r_p0 == BONO_TIPO);
   assign w_hit   = w_event && !w_bono && (r_salto_cnt == 2'd0);
   assign w_dodge = w_event && !w_bono && (r_salto_cnt != 2'd0);

`ifdef VIDAS_EN
   logic [1:0] r_vidas;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        r_vidas <= 2'd3;
      else if (r_state == S_IDLE)        r_vidas <= 2'd3;
      else if (r_state == S_EVAL && w_hit) r_vidas <= r_vidas - 2'd1;
   end

   assign w_last_life = (r_vidas <= 2'd1);
   assign o_vidas     = r_vidas;
`else
   assign w_last_life = 1'b1;
   assign o_vidas     = 2'd1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (i_presente != GAME) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: w_next = S_RUN;
            S_RUN:  if (w_tick_svc) w_next = S_EVAL;
            S_EVAL: begin
               w_next = S_RUN;
               if (w_bono && i_mundo == 2'd2)  w_next = S_WIN;
               else if (w_hit && w_last_life)  w_next = S_LOSE;
            end
            default: w_next = r_state;
         endcase
      end
   end

   always_comb begin
      o_W_or_L    = 2'b00;
      o_heroe_seg = (r_salto_cnt != 2'd0) ? 7'h01 : 7'h08;
      case (r_state)
         S_IDLE:  o_heroe_seg = 7'h00;
         S_WIN:   o_W_or_L    = 2'b10;
         S_LOSE:  o_W_or_L    = 2'b01;
         default: o_W_or_L    = 2'b00;
      endcase
   end

   // A tick landing during EVAL is remembered so RUN still shifts the pipeline for it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {r_p2, r_p1, r_p0} <= '0;
         r_salto_cnt        <= 2'd0;
         r_puntos           <= 8'd0;
         r_bono             <= 1'b0;
         r_tick_pend        <= 1'b0;
      end else if (r_state == S_IDLE) begin
         {r_p2, r_p1, r_p0} <= '0;
         r_salto_cnt        <= 2'd0;
         r_puntos           <= 8'd0;
         r_bono             <= 1'b0;
         r_tick_pend        <= 1'b0;
      end else begin
         if (w_tick) r_bono <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (w_tick_svc) begin
                  r_p2        <= (obs_if.display_obs[20:14] != 7'd0) ? obs_if.tipo_obs : 5'd0;
                  r_p1        <= r_p2;
                  r_p0        <= r_p1;
                  r_tick_pend <= 1'b0;
               end
               if (w_salto_rise && r_salto_cnt == 2'd0) r_salto_cnt <= SALTO_LD;
            end
            S_EVAL: begin
               if (w_tick)                      r_tick_pend <= 1'b1;
               if (r_salto_cnt != 2'd0)         r_salto_cnt <= r_salto_cnt - 2'd1;
               if (w_bono)                      r_bono      <= 1'b1;
               if (w_dodge && r_puntos != 8'hFF) r_puntos   <= r_puntos + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign obs_if.bono_tomado = r_bono;
   assign o_puntos           = r_puntos;

endmodule

// File: tb/tb_detector_colision.sv
// Randomized and directed bench for detector_colision against a tick-level game model.
module tb_detector_colision;
   localparam logic [2:0] GAME    = 3'd3;
   localparam int         T_SALTO = 2;
`ifdef VIDAS_EN
   localparam int VIDAS0 = 3;
`else
   localparam int VIDAS0 = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] presente = 3'd0;
   logic [1:0] mundo = 2'd0;
   logic       salto = 1'b0;
   logic [1:0] w_or_l;
   logic [6:0] heroe;
   logic [7:0] puntos;
   logic [1:0] vidas;

   detector_colision_if u_if();

   always #5 clk = ~clk;

   detector_colision #(.GAME(GAME), .BONO_TIPO(5'd16), .T_SALTO(T_SALTO)) dut (
      .clk(clk), .rst_n(rst_n), .obs_if(u_if),
      .i_presente(presente), .i_mundo(mundo), .i_salto(salto),
      .o_W_or_L(w_or_l), .o_heroe_seg(heroe), .o_puntos(puntos), .o_vidas(vidas)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Game model: digit history per tick, airborne ticks left, score, lives, result.
   logic [4:0] m_hist[3];
   logic [6:0] m_disp[3];
   int         m_air, m_puntos, m_vidas;
   logic [1:0] m_res;
   logic       m_bono;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         m_hist[i] = 5'd0;
         m_disp[i] = 7'd0;
      end
      m_air = 0; m_puntos = 0; m_vidas = VIDAS0; m_res = 2'b00; m_bono = 1'b0;
      u_if.display_obs = 21'd0;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "/wl"},    32'(w_or_l),            32'(m_res));
      chk({tag, "/pts"},   32'(puntos),            32'(m_puntos));
      chk({tag, "/vidas"}, 32'(vidas),             32'(m_vidas));
      chk({tag, "/bono"},  32'(u_if.bono_tomado),  32'(m_bono));
      chk({tag, "/heroe"}, 32'(heroe),             (m_air != 0) ? 32'h01 : 32'h08);
   endtask

   task automatic start_game();
      presente = 3'd0;
      clks(3);
      chk("idle/heroe", 32'(heroe), 32'h00);
      chk("idle/wl",    32'(w_or_l), 32'h0);
      chk("idle/pts",   32'(puntos), 32'h0);
      chk("idle/vidas", 32'(vidas),  32'(VIDAS0));
      model_clear();
      presente = GAME;
      clks(3);
      chk_all("start");
   endtask

   task automatic press_jump();
      salto = 1'b1;
      clks(5);
      salto = 1'b0;
      clks(5);
      if (m_res == 2'b00 && m_air == 0) m_air = T_SALTO;
      chk("jump/heroe", 32'(heroe), (m_res != 2'b00) ? 32'(heroe) : ((m_air != 0) ? 32'h01 : 32'h08));
   endtask

   task automatic step(input bit obst, input logic [4:0] t, input bit blank0, input bit jump);
      if (jump) press_jump();
      m_disp[0] = m_disp[1];
      m_disp[1] = m_disp[2];
      m_disp[2] = obst ? 7'($urandom_range(1, 127)) : 7'd0;
      m_hist[0] = m_hist[1];
      m_hist[1] = m_hist[2];
      m_hist[2] = obst ? t : 5'd0;
      u_if.display_obs    = {m_disp[2], m_disp[1], blank0 ? 7'd0 : m_disp[0]};
      u_if.tipo_obs       = obst ? t : 5'($urandom);
      u_if.clk_obstaculos = 1'b1;
      clks(6);
      u_if.clk_obstaculos = 1'b0;
      clks(6);
      m_bono = 1'b0;
      if (m_res == 2'b00) begin
         if (!blank0 && m_disp[0] != 7'd0 && m_hist[0] != 5'd0) begin
            if (m_hist[0] == 5'd16) begin
               m_bono = 1'b1;
               if (mundo == 2'd2) m_res = 2'b10;
            end else if (m_air > 0) begin
               if (m_puntos < 255) m_puntos++;
            end else begin
`ifdef VIDAS_EN
               m_vidas--;
               if (m_vidas == 0) m_res = 2'b01;
`else
               m_res = 2'b01;
`endif
            end
         end
         if (m_air > 0) m_air--;
      end
      chk_all("step");
   endtask

   task automatic reset_now(input string tag);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk({tag, "/heroe"}, 32'(heroe), 32'h00);
      chk({tag, "/pts"},   32'(puntos), 32'h00);
      chk({tag, "/bono"},  32'(u_if.bono_tomado), 32'h0);
      chk({tag, "/wl"},    32'(w_or_l), 32'h0);
      presente = 3'd0;
      clks(2);
      rst_n = 1'b1;
      clks(4);
      chk({tag, "/idle_heroe"}, 32'(heroe), 32'h00);
      model_clear();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] mundos[3];
      mundos[0] = 2'd0; mundos[1] = 2'd1; mundos[2] = 2'd3;
      u_if.clk_obstaculos = 1'b0;
      u_if.tipo_obs       = 5'd0;
      u_if.display_obs    = 21'd0;
      model_clear();
      clks(3);
      chk("rst/wl",    32'(w_or_l), 32'h0);
      chk("rst/heroe", 32'(heroe),  32'h00);
      chk("rst/pts",   32'(puntos), 32'h0);
      chk("rst/bono",  32'(u_if.bono_tomado), 32'h0);
      chk("rst/vidas", 32'(vidas),  32'(VIDAS0));
      rst_n = 1'b1;
      clks(2);

      // grounded hit on tipo 5
      start_game();
      step(1, 5'd5, 0, 0); step(0, 5'd0, 0, 0); step(0, 5'd0, 0, 0);
`ifndef VIDAS_EN
      chk("hit/lose", 32'(w_or_l), 32'h1);
`endif

      // jump before tick 3, then reset mid-jump
      start_game();
      step(1, 5'd5, 0, 0); step(0, 5'd0, 0, 0); step(0, 5'd0, 0, 1);
      chk("dodge/pts",   32'(puntos), 32'h1);
      chk("dodge/heroe", 32'(heroe),  32'h01);
      step(0, 5'd0, 0, 0);
      chk("land/heroe",  32'(heroe),  32'h08);
      press_jump();
      reset_now("rst_jump");

      // bonus in world 0, then reset mid-bonus, then bonus in world 2
      mundo = 2'd0;
      start_game();
      step(1, 5'd16, 0, 0); step(0, 5'd0, 0, 0); step(0, 5'd0, 0, 0);
      chk("bono/high", 32'(u_if.bono_tomado), 32'h1);
      step(0, 5'd0, 0, 0);
      chk("bono/low",  32'(u_if.bono_tomado), 32'h0);
      step(1, 5'd16, 0, 0); step(0, 5'd0, 0, 0); step(0, 5'd0, 0, 0);
      reset_now("rst_bono");
      mundo = 2'd2;
      start_game();
      step(1, 5'd16, 0, 0); step(1, 5'd5, 0, 0); step(0, 5'd0, 0, 0);
      chk("win/wl", 32'(w_or_l), 32'h2);
      step(0, 5'd0, 0, 1);
      mundo = 2'd0;

      // three grounded hits
      start_game();
      for (int i = 0; i < 6; i++) step(1, 5'd7, 0, 0);
      chk("lives/wl", 32'(w_or_l), 32'h1);
`ifdef VIDAS_EN
      chk("lives/vidas", 32'(vidas), 32'h0);
`endif
      presente = 3'd0;
      @(posedge clk);
      #1;
      chk("lose_exit/wl", 32'(w_or_l), 32'h0);

      // score saturation
      start_game();
      for (int i = 0; i < 302; i++) step(1, 5'd5, 0, 1);
      chk("sat/pts", 32'(puntos), 32'hFF);

      // randomized play
      start_game();
      for (int i = 0; i < 150; i++) begin
         logic [4:0] t;
         if (m_res != 2'b00) start_game();
         mundo = mundos[$urandom_range(0, 2)];
         t = ($urandom_range(0, 9) == 0) ? 5'd16 : 5'($urandom_range(1, 15));
         step(1'($urandom_range(0, 1)), t, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
